// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder: FSM state encodings and the
// default operand width.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  // Default operand / sum width in bits.
  localparam int ADDER_WIDTH_DEF = 8;

  // Controller states. Encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/fa_dec_cell.sv
// -----------------------------------------------------------------------------
// fa_dec_cell
// Purely combinational full-adder cell built from a one-hot decode of the
// three input bits.
//
// Ports:
//   x, y  (in)  : addend bits
//   ci    (in)  : carry in
//   s     (out) : sum bit   = OR of minterms 1,2,4,7
//   co    (out) : carry out = OR of minterms 3,5,6,7
// -----------------------------------------------------------------------------
module fa_dec_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic [2:0] idx_s;
  logic [7:0] dec_s;

  // One-hot decode of {x,y,ci} and minterm OR-planes for sum and carry.
  always_comb begin
    idx_s = {x, y, ci};
    dec_s = 8'b0000_0001 << idx_s;
    s     = |(dec_s & 8'b1001_0110);
    co    = |(dec_s & 8'b1110_1000);
  end

endmodule : fa_dec_cell

// File: rtl/serial_adder_dec.sv
// -----------------------------------------------------------------------------
// serial_adder_dec
// Bit-serial adder: one full-adder cell processes one bit per clock, LSB
// first, with a registered carry. sum/cout only change on entry to DONE.
//
// Parameters:
//   WIDTH : operand and sum width, 2..64
//
// Ports:
//   clk   (in)  : clock, rising edge
//   rst   (in)  : synchronous active-high reset, overrides start
//   start (in)  : request, sampled only in IDLE
//   a, b  (in)  : operands, sampled with start
//   cin   (in)  : carry in, sampled with start
//   sub   (in)  : subtract select, sampled with start (SERIAL_ADDER_SUB_EN only)
//   busy  (out) : high while in RUN
//   done  (out) : one-cycle pulse when sum/cout become valid
//   sum   (out) : result, held until the next done
//   cout  (out) : final carry (no-borrow flag when subtracting)
//
// Build option: define SERIAL_ADDER_SUB_EN to add the sub port and a-b mode.
// -----------------------------------------------------------------------------
module serial_adder_dec
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cell_s, cell_co;

  fa_dec_cell u_cell (
    .x  (opa_q[0]),
    .y  (opb_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opa_d   = a;
          cnt_d   = {CW{1'b0}};
`ifdef SERIAL_ADDER_SUB_EN
          // Two's-complement subtract: a + ~b + 1.
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          opb_d   = b;
          carry_d = cin;
`endif
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        res_d   = {cell_s, res_q[WIDTH-1:1]};
        carry_d = cell_co;
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1'b1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = {cell_s, res_q[WIDTH-1:1]};
          cout_d  = cell_co;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they align with it.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= {WIDTH{1'b0}};
      opb_q   <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder_dec

// File: tb/tb_serial_adder_dec.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_dec
// Self-checking bench for serial_adder_dec (WIDTH=8) against an arithmetic
// reference model. Define SERIAL_ADDER_SUB_EN to also exercise subtraction.
// -----------------------------------------------------------------------------
module tb_serial_adder_dec;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub_i = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_done_cyc = 0;
  logic [W-1:0] held_sum  = '0;
  logic         held_cout = 1'b0;

  serial_adder_dec #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_i),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference: exact (W+1)-bit sum, or modulo difference with no-borrow flag.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    end
    return r;
  endfunction

  // Issues one operation and checks busy/done/sum/cout cycle by cycle.
  // Returns in the IDLE cycle right after done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, input bit disturb);
    logic [W:0] exp;
    exp = model(ta, tb_v, tc, ts);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub_i = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 1; j <= W; j++) begin
      check_eq("busy_run", busy, 1'b1);
      check_eq("done_run", done, 1'b0);
      check_eq("sum_held", sum, held_sum);
      check_eq("cout_held", cout, held_cout);
      if (disturb) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_i = 1'($urandom);
        start = (j == 3) ? 1'b1 : 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_eq("done_pulse", done, 1'b1);
    check_eq("busy_done", busy, 1'b0);
    check_eq("sum", sum, exp[W-1:0]);
    check_eq("cout", cout, exp[W]);
    last_done_cyc = cyc;
    held_sum = exp[W-1:0];
    held_cout = exp[W];
    @(posedge clk); #1;
    check_eq("done_drop", done, 1'b0);
    check_eq("busy_idle", busy, 1'b0);
  endtask

  task automatic idle_no_done(input int n);
    for (int j = 0; j < n; j++) begin
      check_eq("no_done", done, 1'b0);
      check_eq("no_busy", busy, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int first_done;
    logic s_rand;

    // Reset state.
    rst = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_sum", sum, 8'h00);
    check_eq("rst_cout", cout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;

    // Basic add with ignored start and operand changes during RUN.
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
    check_eq("basic_sum", sum, 8'h96);
    idle_no_done(W + 2);

    // Carry ripple and wrap-around.
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    check_eq("ripple_sum", sum, 8'h00);
    check_eq("ripple_cout", cout, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    check_eq("wrap_sum", sum, 8'hFF);
    check_eq("wrap_cout", cout, 1'b1);

    // Back-to-back: start in the IDLE cycle right after done.
    run_op(8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
    first_done = last_done_cyc;
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    check_eq("b2b_spacing", 64'(last_done_cyc - first_done), 64'(W + 2));

    // Reset in the middle of RUN.
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b0; sub_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_rst_busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", done, 1'b0);
    check_eq("midrst_sum", sum, 8'h00);
    check_eq("midrst_cout", cout, 1'b0);
    held_sum = '0;
    held_cout = 1'b0;
    idle_no_done(W + 2);
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    check_eq("fresh_sum", sum, 8'h96);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction: no borrow, then borrow.
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
    check_eq("sub_sum", sum, 8'h0F);
    check_eq("sub_cout", cout, 1'b1);
    run_op(8'h01, 8'h02, 1'b1, 1'b1, 1'b0);
    check_eq("borrow_sum", sum, 8'hFF);
    check_eq("borrow_cout", cout, 1'b0);
`endif

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      s_rand = 1'($urandom_range(0, 1));
`else
      s_rand = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), s_rand, (i % 4) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_adder_dec
